// File: rtl/arith_alu.sv
// Arithmetic/control execution unit: a single registered stage that evaluates
// one integer ALU, jump or branch operation per cycle and broadcasts the result
// on the arithmetic CDB one edge later.
module arith_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        misbranch_flag,
    input  logic [5:0]  openum_in,
    input  logic [31:0] V1_in,
    input  logic [31:0] V2_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] imm_in,
    input  logic [3:0]  rob_id_in,
    output logic        valid_out,
    output logic [3:0]  rob_id_out,
    output logic [31:0] result_out,
    output logic        jump_flag_out,
    output logic [31:0] target_pc_out
);

    // Operation enum shared with the reservation station. Codes 11..18 are
    // loads/stores handled by the LSB; they and anything above 37 are ignored.
    localparam logic [5:0] OPENUM_NOP   = 6'd0;
    localparam logic [5:0] OPENUM_LUI   = 6'd1;
    localparam logic [5:0] OPENUM_AUIPC = 6'd2;
    localparam logic [5:0] OPENUM_JAL   = 6'd3;
    localparam logic [5:0] OPENUM_JALR  = 6'd4;
    localparam logic [5:0] OPENUM_BEQ   = 6'd5;
    localparam logic [5:0] OPENUM_BNE   = 6'd6;
    localparam logic [5:0] OPENUM_BLT   = 6'd7;
    localparam logic [5:0] OPENUM_BGE   = 6'd8;
    localparam logic [5:0] OPENUM_BLTU  = 6'd9;
    localparam logic [5:0] OPENUM_BGEU  = 6'd10;
    localparam logic [5:0] OPENUM_ADDI  = 6'd19;
    localparam logic [5:0] OPENUM_SLTI  = 6'd20;
    localparam logic [5:0] OPENUM_SLTIU = 6'd21;
    localparam logic [5:0] OPENUM_XORI  = 6'd22;
    localparam logic [5:0] OPENUM_ORI   = 6'd23;
    localparam logic [5:0] OPENUM_ANDI  = 6'd24;
    localparam logic [5:0] OPENUM_SLLI  = 6'd25;
    localparam logic [5:0] OPENUM_SRLI  = 6'd26;
    localparam logic [5:0] OPENUM_SRAI  = 6'd27;
    localparam logic [5:0] OPENUM_ADD   = 6'd28;
    localparam logic [5:0] OPENUM_SUB   = 6'd29;
    localparam logic [5:0] OPENUM_SLL   = 6'd30;
    localparam logic [5:0] OPENUM_SLT   = 6'd31;
    localparam logic [5:0] OPENUM_SLTU  = 6'd32;
    localparam logic [5:0] OPENUM_XOR   = 6'd33;
    localparam logic [5:0] OPENUM_SRL   = 6'd34;
    localparam logic [5:0] OPENUM_SRA   = 6'd35;
    localparam logic [5:0] OPENUM_OR    = 6'd36;
    localparam logic [5:0] OPENUM_AND   = 6'd37;

    logic        valid_q,  valid_d;
    logic [3:0]  rob_id_q, rob_id_d;
    logic [31:0] result_q, result_d;
    logic        jump_q,   jump_d;
    logic [31:0] target_q, target_d;

    logic        alu_valid;
    logic [31:0] alu_result;
    logic        alu_jump;
    logic [31:0] alu_target;
    logic [31:0] pc_plus_4;
    logic [31:0] pc_plus_imm;
    logic [31:0] v1_plus_imm;
    logic [4:0]  shamt_reg;
    logic [4:0]  shamt_imm;

    assign pc_plus_4   = pc_in + 32'd4;
    assign pc_plus_imm = pc_in + imm_in;
    assign v1_plus_imm = V1_in + imm_in;
    assign shamt_reg   = V2_in[4:0];
    assign shamt_imm   = imm_in[4:0];

    // Decode and evaluate the incoming operation; non-arith enums yield an
    // all-zero, invalid result so idle CDB fields stay clean.
    always_comb begin
        alu_valid  = 1'b1;
        alu_result = 32'd0;
        alu_jump   = 1'b0;
        alu_target = pc_plus_4;
        case (openum_in)
            OPENUM_LUI:   alu_result = imm_in;
            OPENUM_AUIPC: alu_result = pc_plus_imm;
            OPENUM_JAL: begin
                alu_result = pc_plus_4;
                alu_target = pc_plus_imm;
                alu_jump   = 1'b1;
            end
            OPENUM_JALR: begin
                alu_result = pc_plus_4;
                alu_target = {v1_plus_imm[31:1], 1'b0};
                alu_jump   = 1'b1;
            end
            OPENUM_BEQ:  begin alu_target = pc_plus_imm; alu_jump = (V1_in == V2_in); end
            OPENUM_BNE:  begin alu_target = pc_plus_imm; alu_jump = (V1_in != V2_in); end
            OPENUM_BLT:  begin alu_target = pc_plus_imm; alu_jump = ($signed(V1_in) <  $signed(V2_in)); end
            OPENUM_BGE:  begin alu_target = pc_plus_imm; alu_jump = ($signed(V1_in) >= $signed(V2_in)); end
            OPENUM_BLTU: begin alu_target = pc_plus_imm; alu_jump = (V1_in <  V2_in); end
            OPENUM_BGEU: begin alu_target = pc_plus_imm; alu_jump = (V1_in >= V2_in); end
            OPENUM_ADDI:  alu_result = v1_plus_imm;
            OPENUM_SLTI:  alu_result = {31'd0, ($signed(V1_in) < $signed(imm_in))};
            OPENUM_SLTIU: alu_result = {31'd0, (V1_in < imm_in)};
            OPENUM_XORI:  alu_result = V1_in ^ imm_in;
            OPENUM_ORI:   alu_result = V1_in | imm_in;
            OPENUM_ANDI:  alu_result = V1_in & imm_in;
            OPENUM_SLLI:  alu_result = V1_in << shamt_imm;
            OPENUM_SRLI:  alu_result = V1_in >> shamt_imm;
            OPENUM_SRAI:  alu_result = $unsigned($signed(V1_in) >>> shamt_imm);
            OPENUM_ADD:   alu_result = V1_in + V2_in;
            OPENUM_SUB:   alu_result = V1_in - V2_in;
            OPENUM_SLL:   alu_result = V1_in << shamt_reg;
            OPENUM_SLT:   alu_result = {31'd0, ($signed(V1_in) < $signed(V2_in))};
            OPENUM_SLTU:  alu_result = {31'd0, (V1_in < V2_in)};
            OPENUM_XOR:   alu_result = V1_in ^ V2_in;
            OPENUM_SRL:   alu_result = V1_in >> shamt_reg;
            OPENUM_SRA:   alu_result = $unsigned($signed(V1_in) >>> shamt_reg);
            OPENUM_OR:    alu_result = V1_in | V2_in;
            OPENUM_AND:   alu_result = V1_in & V2_in;
            default: begin
                alu_valid  = 1'b0;
                alu_target = 32'd0;
            end
        endcase
    end

    // Next-state selection: a flush wins even while stalled, a stall holds.
    always_comb begin
        valid_d  = valid_q;
        rob_id_d = rob_id_q;
        result_d = result_q;
        jump_d   = jump_q;
        target_d = target_q;
        if (misbranch_flag) begin
            valid_d  = 1'b0;
            rob_id_d = 4'd0;
            result_d = 32'd0;
            jump_d   = 1'b0;
            target_d = 32'd0;
        end else if (rdy) begin
            valid_d  = alu_valid;
            rob_id_d = alu_valid ? rob_id_in  : 4'd0;
            result_d = alu_valid ? alu_result : 32'd0;
            jump_d   = alu_valid & alu_jump;
            target_d = alu_valid ? alu_target : 32'd0;
        end
    end

    // Output register with asynchronous clear so a reset kills a pending broadcast at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            rob_id_q <= 4'd0;
            result_q <= 32'd0;
            jump_q   <= 1'b0;
            target_q <= 32'd0;
        end else begin
            valid_q  <= valid_d;
            rob_id_q <= rob_id_d;
            result_q <= result_d;
            jump_q   <= jump_d;
            target_q <= target_d;
        end
    end

    assign valid_out     = valid_q;
    assign rob_id_out    = rob_id_q;
    assign result_out    = result_q;
    assign jump_flag_out = jump_q;
    assign target_pc_out = target_q;

endmodule

// File: tb/tb_arith_alu.sv
// Self-checking bench for arith_alu: expected broadcasts are queued when an
// instruction is driven and compared one edge later.
module tb_arith_alu;

    localparam logic [5:0] NOP = 6'd0,  LUI = 6'd1,  AUIPC = 6'd2, JAL = 6'd3, JALR = 6'd4;
    localparam logic [5:0] BEQ = 6'd5,  BNE = 6'd6,  BLT = 6'd7,   BGE = 6'd8, BLTU = 6'd9, BGEU = 6'd10;
    localparam logic [5:0] LW  = 6'd13, SW  = 6'd18;
    localparam logic [5:0] ADDI = 6'd19, SLTI = 6'd20, SLTIU = 6'd21, XORI = 6'd22, ORI = 6'd23, ANDI = 6'd24;
    localparam logic [5:0] SLLI = 6'd25, SRLI = 6'd26, SRAI = 6'd27;
    localparam logic [5:0] ADD = 6'd28, SUB = 6'd29, SLL = 6'd30, SLT = 6'd31, SLTU = 6'd32, XOR = 6'd33;
    localparam logic [5:0] SRL = 6'd34, SRA = 6'd35, OR = 6'd36, AND = 6'd37;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        misbranch_flag = 1'b0;
    logic [5:0]  openum_in = 6'd0;
    logic [31:0] V1_in = 32'd0, V2_in = 32'd0, pc_in = 32'd0, imm_in = 32'd0;
    logic [3:0]  rob_id_in = 4'd0;
    logic        valid_out;
    logic [3:0]  rob_id_out;
    logic [31:0] result_out;
    logic        jump_flag_out;
    logic [31:0] target_pc_out;

    int checks = 0;
    int errors = 0;
    logic [69:0] sb[$];

    arith_alu dut (
        .clk(clk), .rst(rst), .rdy(rdy), .misbranch_flag(misbranch_flag),
        .openum_in(openum_in), .V1_in(V1_in), .V2_in(V2_in), .pc_in(pc_in),
        .imm_in(imm_in), .rob_id_in(rob_id_in), .valid_out(valid_out),
        .rob_id_out(rob_id_out), .result_out(result_out),
        .jump_flag_out(jump_flag_out), .target_pc_out(target_pc_out)
    );

    always #5 clk = ~clk;

    // {valid, rob, result, jump, target}
    function automatic logic [69:0] mk(input logic v, input logic [3:0] rob, input logic [31:0] res,
                                       input logic j, input logic [31:0] tgt);
        return {v, rob, res, j, tgt};
    endfunction

    function automatic logic [69:0] observed();
        return {valid_out, rob_id_out, result_out, jump_flag_out, target_pc_out};
    endfunction

    // Reference behaviour, written from the instruction semantics.
    function automatic logic [69:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] rob);
        logic signed [31:0] sa, sb_, si;
        sa = a; sb_ = b; si = imm;
        case (op)
            LUI:   return mk(1, rob, imm, 0, pc + 4);
            AUIPC: return mk(1, rob, pc + imm, 0, pc + 4);
            JAL:   return mk(1, rob, pc + 4, 1, pc + imm);
            JALR:  return mk(1, rob, pc + 4, 1, (a + imm) & 32'hFFFF_FFFE);
            BEQ:   return mk(1, rob, 0, a == b, pc + imm);
            BNE:   return mk(1, rob, 0, a != b, pc + imm);
            BLT:   return mk(1, rob, 0, sa < sb_, pc + imm);
            BGE:   return mk(1, rob, 0, !(sa < sb_), pc + imm);
            BLTU:  return mk(1, rob, 0, a < b, pc + imm);
            BGEU:  return mk(1, rob, 0, !(a < b), pc + imm);
            ADDI:  return mk(1, rob, a + imm, 0, pc + 4);
            SLTI:  return mk(1, rob, (sa < si) ? 32'd1 : 32'd0, 0, pc + 4);
            SLTIU: return mk(1, rob, (a < imm) ? 32'd1 : 32'd0, 0, pc + 4);
            XORI:  return mk(1, rob, a ^ imm, 0, pc + 4);
            ORI:   return mk(1, rob, a | imm, 0, pc + 4);
            ANDI:  return mk(1, rob, a & imm, 0, pc + 4);
            SLLI:  return mk(1, rob, a << imm[4:0], 0, pc + 4);
            SRLI:  return mk(1, rob, a >> imm[4:0], 0, pc + 4);
            SRAI:  return mk(1, rob, 32'(sa >>> imm[4:0]), 0, pc + 4);
            ADD:   return mk(1, rob, a + b, 0, pc + 4);
            SUB:   return mk(1, rob, a - b, 0, pc + 4);
            SLL:   return mk(1, rob, a << b[4:0], 0, pc + 4);
            SLT:   return mk(1, rob, (sa < sb_) ? 32'd1 : 32'd0, 0, pc + 4);
            SLTU:  return mk(1, rob, (a < b) ? 32'd1 : 32'd0, 0, pc + 4);
            XOR:   return mk(1, rob, a ^ b, 0, pc + 4);
            SRL:   return mk(1, rob, a >> b[4:0], 0, pc + 4);
            SRA:   return mk(1, rob, 32'(sa >>> b[4:0]), 0, pc + 4);
            OR:    return mk(1, rob, a | b, 0, pc + 4);
            AND:   return mk(1, rob, a & b, 0, pc + 4);
            default: return 70'd0;
        endcase
    endfunction

    // Apply one instruction on the falling edge, then step past the next rising edge.
    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] rob,
                         input logic mis, input logic r);
        @(negedge clk);
        openum_in = op; V1_in = a; V2_in = b; pc_in = pc; imm_in = imm;
        rob_id_in = rob; misbranch_flag = mis; rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [69:0] got;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(ADD, 32'd5, 32'd7, 32'h40, 32'd0, 4'd9, 1'b0, 1'b1);
            got = observed();
            checks++;
            if (got !== 70'd0) begin
                errors++;
                $display("FAIL reset_hold%0d got=%h exp=%h", i, got, 70'd0);
            end
            $display("txn reset cycle %0d out=%h", i, got);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_vectors();
        logic [5:0]  op [6] = '{ADD, SRA, SRAI, BLT, BLTU, JALR};
        logic [31:0] a  [6] = '{32'h7FFF_FFFF, 32'h8000_0010, 32'h8000_0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1003};
        logic [31:0] b  [6] = '{32'd1, 32'h24, 32'd0, 32'd1, 32'd1, 32'd0};
        logic [31:0] pc [6] = '{32'h10, 32'h20, 32'h24, 32'h100, 32'h100, 32'h200};
        logic [31:0] im [6] = '{32'd0, 32'd0, 32'd4, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'd4};
        logic [3:0]  rb [6] = '{4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd5};
        logic [69:0] exp [6];
        logic [69:0] e, got;
        exp[0] = mk(1, 4'd3, 32'h8000_0000, 0, 32'h14);
        exp[1] = mk(1, 4'd4, 32'hF800_0001, 0, 32'h24);
        exp[2] = mk(1, 4'd6, 32'hF800_0001, 0, 32'h28);
        exp[3] = mk(1, 4'd7, 32'd0, 1, 32'hF0);
        exp[4] = mk(1, 4'd8, 32'd0, 0, 32'hF0);
        exp[5] = mk(1, 4'd5, 32'h204, 1, 32'h1006);
        for (int i = 0; i < 6; i++) begin
            sb.push_back(exp[i]);
            drive(op[i], a[i], b[i], pc[i], im[i], rb[i], 1'b0, 1'b1);
            e = sb.pop_front();
            got = observed();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL vector%0d op=%0d got=%h exp=%h", i, op[i], got, e);
            end
            $display("txn vector%0d op=%0d out=%h", i, op[i], got);
        end
    endtask

    task automatic test_flush_stall();
        logic [5:0]  op  [7] = '{ADD, ADD, SUB, ADD, ADD, NOP, LW};
        logic        mis [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        r   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [69:0] exp [7];
        logic [69:0] e, got;
        exp[0] = 70'd0;
        exp[1] = mk(1, 4'd2, 32'd11, 0, 32'h84);
        exp[2] = exp[1];
        exp[3] = 70'd0;
        exp[4] = 70'd0;
        exp[5] = 70'd0;
        exp[6] = 70'd0;
        for (int i = 0; i < 7; i++) begin
            sb.push_back(exp[i]);
            drive(op[i], 32'd5 + 32'(i == 0), 32'd6, 32'h80, 32'h10, 4'd1 + 4'(i), mis[i], r[i]);
            e = sb.pop_front();
            got = observed();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL flush_stall%0d got=%h exp=%h", i, got, e);
            end
            $display("txn flush_stall%0d op=%0d mis=%0b rdy=%0b out=%h", i, op[i], mis[i], r[i], got);
        end
    endtask

    task automatic test_async_reset();
        logic [69:0] e, got;
        sb.push_back(mk(1, 4'd4, 32'd3, 0, 32'h304));
        drive(ADD, 32'd1, 32'd2, 32'h300, 32'd0, 4'd4, 1'b0, 1'b1);
        e = sb.pop_front();
        got = observed();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL async_pre got=%h exp=%h", got, e);
        end
        #1 rst = 1'b0;
        #1;
        got = observed();
        checks++;
        if (got !== 70'd0) begin
            errors++;
            $display("FAIL async_clear got=%h exp=%h", got, 70'd0);
        end
        $display("txn async reset mid-cycle out=%h", got);
        @(negedge clk);
        rst = 1'b1;
        sb.push_back(mk(1, 4'd6, 32'h1234_5000, 0, 32'h404));
        drive(LUI, 32'd0, 32'd0, 32'h400, 32'h1234_5000, 4'd6, 1'b0, 1'b1);
        e = sb.pop_front();
        got = observed();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL lui_after_reset got=%h exp=%h", got, e);
        end
        $display("txn lui after reset out=%h", got);
    endtask

    task automatic test_back_to_back();
        logic [5:0]  op;
        logic [31:0] a, b, pc, im;
        logic [3:0]  rob;
        logic [69:0] e, got;
        for (int i = 0; i < 200; i++) begin
            op  = 6'($urandom_range(0, 40));
            a   = $urandom;
            b   = (i % 4 == 0) ? a : $urandom;
            pc  = $urandom;
            im  = $urandom;
            rob = 4'($urandom);
            sb.push_back(model(op, a, b, pc, im, rob));
            drive(op, a, b, pc, im, rob, 1'b0, 1'b1);
            e = sb.pop_front();
            got = observed();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL b2b%0d op=%0d got=%h exp=%h", i, op, got, e);
            end
            $display("txn b2b%0d op=%0d out=%h", i, op, got);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_flush_stall();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arith_alu.md
ARITH_ALU -- requirements
Module: arith_alu

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately, independent of clk).
REQ-003 rdy  input  1  global ready; rdy=0 freezes all registers.
REQ-004 misbranch_flag  input  1  pipeline flush from commit.
REQ-005 openum_in  input  6  operation enum from reservation station; OPENUM_NOP = no instruction.
REQ-006 V1_in  input  32  operand 1 (rs1 value).
REQ-007 V2_in  input  32  operand 2 (rs2 value).
REQ-008 pc_in  input  32  instruction address.
REQ-009 imm_in  input  32  sign-extended immediate.
REQ-010 rob_id_in  input  4  destination ROB entry.
REQ-011 valid_out  output  1  result broadcast on arith CDB this cycle.
REQ-012 rob_id_out  output  4  ROB entry of broadcast result.
REQ-013 result_out  output  32  value written to rd.
REQ-014 jump_flag_out  output  1  control transfer taken.
REQ-015 target_pc_out  output  32  taken target address.

Function
REQ-016 All outputs SHALL be registered; inputs sampled at edge N appear on outputs after edge N, held until edge N+1 (latency 1, throughput 1/cycle, no backpressure).
REQ-017 valid_out SHALL be 1 after an edge only if openum_in was an arithmetic/control enum at that edge; OPENUM_NOP or any load/store/unknown enum SHALL give valid_out=0, jump_flag_out=0.
REQ-018 When valid_out=0, rob_id_out, result_out, target_pc_out SHALL be 0.
REQ-019 LUI: result=imm; AUIPC: result=pc+imm.
REQ-020 ADD/SUB/AND/OR/XOR: V1 op V2; ADDI/ANDI/ORI/XORI: V1 op imm; all modulo 2^32.
REQ-021 SLT/SLTI signed compare, SLTU/SLTIU unsigned compare; result 1 or 0.
REQ-022 SLL/SRL/SRA shift amount V2[4:0]; SLLI/SRLI/SRAI shift amount imm[4:0]; SRA/SRAI arithmetic (sign-filling).
REQ-023 JAL: result=pc+4, target=pc+imm, jump=1.
REQ-024 JALR: result=pc+4, target=(V1+imm) with bit0 cleared, jump=1.
REQ-025 BEQ/BNE/BLT/BGE/BLTU/BGEU: result=0, target=pc+imm, jump=condition(V1,V2) (BLT/BGE signed, BLTU/BGEU unsigned).
REQ-026 Non-jump, non-branch ops SHALL give jump_flag_out=0, target_pc_out=pc+4.
REQ-027 misbranch_flag=1 at an edge (with rdy=1) SHALL clear all outputs to 0 regardless of inputs; the instruction at that edge is discarded.
REQ-028 misbranch_flag SHALL take priority over rdy=0 (flush still applies when rdy=0).
REQ-029 rdy=0 without misbranch SHALL hold all outputs unchanged; a held valid_out=1 remains asserted (consumers gate on rdy).
REQ-030 Adder wrap: pc+imm, V1+imm overflow SHALL wrap modulo 2^32 without flag.

Reset
REQ-031 rst=0 SHALL asynchronously force valid_out=0, jump_flag_out=0, rob_id_out=0, result_out=0, target_pc_out=0.
REQ-032 While rst=0, inputs SHALL be ignored; first capture on first rising edge with rst=1 and rdy=1.
REQ-033 rst asserted mid-stream SHALL drop any pending broadcast immediately (same cycle, no edge needed).

Verification
REQ-034 ADD V1=0x7FFFFFFF, V2=1, rob=3 -> next cycle valid=1, rob=3, result=0x80000000, jump=0.
REQ-035 SRA V1=0x80000010, V2=0x24 -> result=0xF8000001 (shift 4); SRAI same V1, imm=4 -> same result.
REQ-036 BLT V1=0xFFFFFFFF, V2=1, pc=0x100, imm=0xFFFFFFF0 -> jump=1, target=0xF0, result=0; BLTU same operands -> jump=0.
REQ-037 JALR V1=0x1003, imm=4, pc=0x200, rob=5 -> result=0x204, target=0x1006, jump=1.
REQ-038 Issue ADD in cycle N with misbranch_flag=1 -> valid=0 after edge; then rdy=0 with ADD input -> outputs held at 0; OPENUM_NOP input -> valid=0.
REQ-039 Assert rst=0 between edges while valid_out=1 -> all outputs 0 before next edge; release rst, issue LUI imm=0x12345000 -> result=0x12345000, valid=1 one edge later.
